// File: rtl/wait_event_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wait_event_pkg
// Description : Shared types, command words and time-unit helpers for the
//               wait_event_engine block.
//               - wait_state_e  : engine FSM states (IDLE, ARMED, DONE)
//               - CMD_WTR/WTF   : command words recognised in i_args[0]
//               - unit_to_ps    : time-unit string -> picoseconds
//               - timeout_cycles: decimal value + unit -> clock cycles
// Revision    : 1.0 - initial release
// ============================================================================
package wait_event_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } wait_state_e;

    localparam string CMD_WTR = "WTR";
    localparam string CMD_WTF = "WTF";

    // Anything that is not a known unit falls back to nanoseconds.
    function automatic longint unsigned unit_to_ps(input string unit);
        if (unit == "ps") return 64'd1;
        if (unit == "ns") return 64'd1000;
        if (unit == "us") return 64'd1000000;
        if (unit == "ms") return 64'd1000000000;
        return 64'd1000;
    endfunction

    // ceil(value * unit / clk_ps), clamped to at least one cycle so that a
    // zero or tiny timeout still leaves a single ARMED cycle.
    function automatic longint unsigned timeout_cycles(input string value,
                                                       input string unit,
                                                       input longint unsigned clk_ps);
        int              raw;
        longint unsigned v;
        longint unsigned cyc;
        raw = value.atoi();
        v   = (raw < 0) ? 64'd0 : 64'(raw);
        cyc = (v * unit_to_ps(unit) + clk_ps - 64'd1) / clk_ps;
        return (cyc == 64'd0) ? 64'd1 : cyc;
    endfunction

endpackage : wait_event_pkg
`default_nettype wire

// File: rtl/wait_event_timer.sv
`default_nettype none
// ============================================================================
// Module      : wait_event_timer
// Description : Down-counting timeout counter for wait_event_engine.
//               A load writes the cycle budget; the counter then decrements
//               every cycle and flags expiry during its last cycle so the
//               engine leaves ARMED exactly <value> cycles after the load.
// Ports       : clk     - rising-edge clock
//               rst_n   - asynchronous active-low reset (counter -> 0)
//               load    - load <value> into the counter
//               value   - cycle budget (>= 1)
//               expired - high while the final cycle of the budget runs
// Revision    : 1.0 - initial release
// ============================================================================
module wait_event_timer #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CNT_W'(1));

endmodule : wait_event_timer
`default_nettype wire

// File: rtl/wait_event_engine.sv
`default_nettype none
// ============================================================================
// Module      : wait_event_engine
// Description : Command-driven edge waiter. A "WTR"/"WTF" command names a
//               watched signal by alias; the engine arms, watches bit 0 of
//               that signal for a rising/falling edge and emits a one-cycle
//               o_wait_done pulse when it sees it.
// Ports       : clk          - rising-edge clock
//               rst_n        - asynchronous active-low reset
//               i_wait_alias - alias name per watched signal
//               i_sel_wait   - command addressed to this block
//               i_args_valid - i_args valid this cycle
//               i_args       - [0] cmd, [1] alias, [2] timeout, [3] unit
//               i_wait       - watched signals
//               o_wait_done  - registered one-cycle completion pulse
// Config      : WAIT_EVENT_TIMEOUT_EN - when defined, a timeout counter
//               ends the wait after i_args[2] i_args[3] and prints
//               "WAIT TIMEOUT <alias>"; otherwise ARMED waits for the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module wait_event_engine
    import wait_event_pkg::*;
#(
    parameter int ARGS_NB    = 5,
    parameter int WAIT_SIZE  = 5,
    parameter int WAIT_WIDTH = 1,
    parameter int CLK_PERIOD = 20000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  string                 i_wait_alias [WAIT_SIZE],
    input  logic                  i_sel_wait,
    input  logic                  i_args_valid,
    input  string                 i_args [ARGS_NB],
    input  logic [WAIT_WIDTH-1:0] i_wait [WAIT_SIZE],
    output logic                  o_wait_done
);

    localparam int IDX_W = (WAIT_SIZE > 1) ? $clog2(WAIT_SIZE) : 1;

    if (ARGS_NB < 4 || WAIT_SIZE < 1 || CLK_PERIOD <= 0) begin : g_param_check
        $error("wait_event_engine: ARGS_NB must be >= 4, WAIT_SIZE >= 1, CLK_PERIOD > 0");
    end

    wait_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             rise_q, rise_d;
    logic             prev_q, prev_d;
    logic             done_q, done_d;

    logic             w_accept;
    logic             w_is_wtr;
    logic             w_is_wtf;
    logic             w_cmd_ok;
    logic             w_alias_hit;
    logic [IDX_W-1:0] w_alias_idx;
    logic             w_cur;
    logic             w_edge;
    logic             w_arm;
    logic             w_expired;

    assign w_accept = i_sel_wait && i_args_valid && (state_q == IDLE);
    assign w_is_wtr = (i_args[0] == CMD_WTR);
    assign w_is_wtf = (i_args[0] == CMD_WTF);
    assign w_cmd_ok = w_is_wtr || w_is_wtf;
    assign w_arm    = w_accept && w_cmd_ok && w_alias_hit;

    // Scan from the top down so the lowest matching index wins.
    always_comb begin
        w_alias_hit = 1'b0;
        w_alias_idx = '0;
        for (int i = WAIT_SIZE - 1; i >= 0; i--) begin
            if (i_wait_alias[i] == i_args[1]) begin
                w_alias_hit = 1'b1;
                w_alias_idx = IDX_W'(i);
            end
        end
    end

    // Case equality keeps X/Z samples from ever qualifying as an edge.
    assign w_cur  = i_wait[idx_q][0];
    assign w_edge = (state_q == ARMED) &&
                    (rise_q ? ((prev_q === 1'b0) && (w_cur === 1'b1))
                            : ((prev_q === 1'b1) && (w_cur === 1'b0)));

`ifdef WAIT_EVENT_TIMEOUT_EN
    logic [63:0] w_tmo_cycles;

    always_comb begin
        w_tmo_cycles = timeout_cycles(i_args[2], i_args[3], 64'(CLK_PERIOD));
    end

    wait_event_timer #(
        .CNT_W (64)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_arm),
        .value   (w_tmo_cycles),
        .expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rise_d  = rise_q;
        prev_d  = prev_q;
        case (state_q)
            IDLE: begin
                if (w_accept && w_cmd_ok) begin
                    if (w_alias_hit) begin
                        state_d = ARMED;
                        idx_d   = w_alias_idx;
                        rise_d  = w_is_wtr;
                        // Seed with the accept-cycle sample so a transition
                        // coinciding with the command is not an event.
                        prev_d  = i_wait[w_alias_idx][0];
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ARMED: begin
                prev_d = w_cur;
                if (w_edge || w_expired) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rise_q  <= 1'b0;
            prev_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rise_q  <= rise_d;
            prev_q  <= prev_d;
            done_q  <= done_d;
        end
    end

    assign o_wait_done = done_q;

    // Simulation messages for ignored commands, unresolved aliases and
    // timeouts; an edge in the expiry cycle wins, so no timeout message.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_accept && !w_cmd_ok) begin
                $display("wait_event_engine: warning, ignoring unknown command '%s'", i_args[0]);
            end
            if (w_accept && w_cmd_ok && !w_alias_hit) begin
                $display("wait_event_engine: error, no alias matches '%s'", i_args[1]);
            end
            if ((state_q == ARMED) && w_expired && !w_edge) begin
                $display("WAIT TIMEOUT %s", i_wait_alias[idx_q]);
            end
        end
    end

endmodule : wait_event_engine
`default_nettype wire

// File: tb/tb_wait_event_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_wait_event_engine
// Description : Self-checking bench for wait_event_engine. A table of
//               command vectors is applied in a loop, each checking the
//               cycle of the o_wait_done pulse relative to the accept edge
//               and that exactly one pulse appears; hand sequences cover
//               reset, busy-command rejection, reset mid-wait and (with
//               WAIT_EVENT_TIMEOUT_EN) the long timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wait_event_engine;

    localparam int ARGS_NB   = 5;
    localparam int WAIT_SIZE = 5;

    logic       clk;
    logic       rst_n;
    string      aliases [WAIT_SIZE];
    logic       sel;
    logic       valid;
    string      args [ARGS_NB];
    logic [0:0] wait_sig [WAIT_SIZE];
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string name;
        string cmd;
        string alias_s;
        string val;
        string unit;
        int    sig;
        int    pre;
        int    at_cmd;
        int    d1_after;
        int    d1_lvl;
        int    d2_after;
        int    d2_lvl;
        int    exp;
    } vec_t;

    vec_t vecs [6];

    wait_event_engine #(
        .ARGS_NB    (ARGS_NB),
        .WAIT_SIZE  (WAIT_SIZE),
        .WAIT_WIDTH (1),
        .CLK_PERIOD (20000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_wait_alias (aliases),
        .i_sel_wait   (sel),
        .i_args_valid (valid),
        .i_args       (args),
        .i_wait       (wait_sig),
        .o_wait_done  (done)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic vec_t mk(string name, string cmd, string al, string val, string unit,
                                int sig, int pre, int at_cmd, int d1a, int d1l,
                                int d2a, int d2l, int exp);
        vec_t v;
        v.name = name; v.cmd = cmd; v.alias_s = al; v.val = val; v.unit = unit;
        v.sig = sig; v.pre = pre; v.at_cmd = at_cmd;
        v.d1_after = d1a; v.d1_lvl = d1l; v.d2_after = d2a; v.d2_lvl = d2l;
        v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic issue(input string cmd, input string al, input string val, input string unit);
        args[0] = cmd; args[1] = al; args[2] = val; args[3] = unit; args[4] = "";
        sel   = 1'b1;
        valid = 1'b1;
    endtask

    // Called just after a rising edge. Cycle c of the loop runs just after
    // accept edge + c; a drive at c is sampled at edge c+1.
    task automatic run_vec(input vec_t v);
        int first;
        int highs;
        int win;
        wait_sig[v.sig] = 1'(v.pre);
        @(posedge clk); #1;
        issue(v.cmd, v.alias_s, v.val, v.unit);
        wait_sig[v.sig] = 1'(v.at_cmd);
        @(posedge clk); #1;
        sel   = 1'b0;
        valid = 1'b0;
        first = -1;
        highs = 0;
        win   = (v.exp >= 0) ? v.exp + 3 : 6;
        for (int c = 0; c <= win; c++) begin
            if (c == v.d1_after) wait_sig[v.sig] = 1'(v.d1_lvl);
            if (c == v.d2_after) wait_sig[v.sig] = 1'(v.d2_lvl);
            @(negedge clk);
            if (done) begin
                if (first < 0) first = c;
                highs++;
            end
            @(posedge clk); #1;
        end
        check({v.name, " latency"}, first, v.exp);
        check({v.name, " pulses"}, highs, (v.exp >= 0) ? 1 : 0);
    endtask

    initial begin
        int first;
        int highs;

        aliases[0] = "O1"; aliases[1] = "O2"; aliases[2] = "O3";
        aliases[3] = "O4"; aliases[4] = "RST_N";
        for (int i = 0; i < WAIT_SIZE; i++) wait_sig[i] = 1'b0;
        wait_sig[4] = 1'b1;
        for (int i = 0; i < ARGS_NB; i++) args[i] = "";
        sel   = 1'b0;
        valid = 1'b0;
        rst_n = 1'b0;

        //         name         cmd    alias  val    unit sig pre at d1a d1l d2a d2l exp
        vecs[0] = mk("wtr_o1",   "WTR", "O1",  "100", "us", 0, 0, 0, 10, 1, -1, 0, 11);
        vecs[1] = mk("bad_alias","WTR", "BAD", "10",  "ns", 0, 0, 0, -1, 0, -1, 0, 0);
        vecs[2] = mk("wtf_o2",   "WTF", "O2",  "1",   "us", 1, 1, 1,  3, 0, -1, 0, 4);
        vecs[3] = mk("tie_o4",   "WTR", "O4",  "40",  "ns", 3, 0, 0,  1, 1, -1, 0, 2);
        vecs[4] = mk("bad_cmd",  "XYZ", "O1",  "1",   "us", 0, 0, 0,  1, 1, -1, 0, -1);
        vecs[5] = mk("acc_edge", "WTR", "O3",  "1",   "us", 2, 0, 1,  3, 0,  6, 1, 7);

        // Reset state
        repeat (2) @(negedge clk);
        check("reset done", int'(done), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset done", int'(done), 0);
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Second command while ARMED on O1 must be ignored; O2 edge is a decoy.
        wait_sig[0] = 1'b0;
        wait_sig[1] = 1'b0;
        @(posedge clk); #1;
        issue("WTR", "O1", "1", "us");
        @(posedge clk); #1;
        sel = 1'b0; valid = 1'b0;
        first = -1; highs = 0;
        for (int c = 0; c <= 14; c++) begin
            if (c == 2) issue("WTR", "O2", "1", "us");
            if (c == 3) begin sel = 1'b0; valid = 1'b0; end
            if (c == 4) wait_sig[1] = 1'b1;
            if (c == 8) wait_sig[0] = 1'b1;
            @(negedge clk);
            if (done) begin
                if (first < 0) first = c;
                highs++;
            end
            @(posedge clk); #1;
        end
        check("busy latency", first, 9);
        check("busy pulses", highs, 1);

        // Reset asserted mid-wait: no pulse, even when the edge arrives later.
        wait_sig[0] = 1'b0;
        @(posedge clk); #1;
        issue("WTR", "O1", "1", "us");
        @(posedge clk); #1;
        sel = 1'b0; valid = 1'b0;
        highs = 0;
        for (int c = 0; c <= 12; c++) begin
            if (c == 3) rst_n = 1'b0;
            if (c == 5) rst_n = 1'b1;
            if (c == 7) wait_sig[0] = 1'b1;
            @(negedge clk);
            if (done) highs++;
            @(posedge clk); #1;
        end
        check("abort pulses", highs, 0);
        run_vec(mk("after_rst", "WTR", "O3", "1", "us", 2, 0, 0, 2, 1, -1, 0, 3));

`ifdef WAIT_EVENT_TIMEOUT_EN
        run_vec(mk("timeout", "WTF", "RST_N", "1", "ms", 4, 1, 1, -1, 0, -1, 0, 50000));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_wait_event_engine
`default_nettype wire

// File: doc/wait_event_engine.md
WAIT_EVENT_ENGINE -- requirements
Module: wait_event_engine

Interface
REQ-001 SHALL have parameter ARGS_NB, default 5, number of command argument strings.
REQ-002 SHALL have parameter WAIT_SIZE, default 5, number of watched signals/aliases.
REQ-003 SHALL have parameter WAIT_WIDTH, default 1, width of each watched signal.
REQ-004 SHALL have parameter CLK_PERIOD, default 20000, clock period in ps.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-007 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have port i_wait_alias, input, string[WAIT_SIZE], alias name per watched signal.
REQ-009 SHALL have port i_sel_wait, input, 1 bit, command addressed to this block.
REQ-010 SHALL have port i_args_valid, input, 1 bit, i_args valid this cycle.
REQ-011 SHALL have port i_args, input, string[ARGS_NB], command words: [0] cmd, [1] alias, [2] decimal timeout, [3] unit.
REQ-012 SHALL have port i_wait, input, [WAIT_WIDTH-1:0][WAIT_SIZE], watched signals.
REQ-013 SHALL have port o_wait_done, output, 1 bit, one-cycle completion pulse.

Function
REQ-014 SHALL accept a command only on a rising clk edge with i_sel_wait=1, i_args_valid=1 and state IDLE.
- Commands received in any other state SHALL be ignored.
REQ-015 SHALL recognise these values of i_args[0]:
- "WTR": wait for a rising edge (0->1) on bit 0 of the aliased signal.
- "WTF": wait for a falling edge (1->0) on bit 0 of the aliased signal.
- Any other value SHALL be ignored, with a $display warning.
REQ-016 SHALL resolve i_args[1] by exact string match against i_wait_alias, taking the lowest index that matches.
- If no alias matches: $display an error, go to DONE, pulse o_wait_done.
REQ-017 SHALL compute the timeout in cycles as ceil(value*unit_ps/CLK_PERIOD).
- Units: "ps"=1, "ns"=1000, "us"=1e6, "ms"=1e9.
- An unknown unit SHALL be treated as "ns".
- A computed value of 0 SHALL become 1.
REQ-018 SHALL implement states IDLE -> ARMED -> DONE -> IDLE.
- Accepting a command in IDLE SHALL go to ARMED.
- ARMED SHALL go to DONE on the qualifying edge or on timeout.
- DONE SHALL last exactly one cycle, with o_wait_done=1.
REQ-019 SHALL detect edges by comparing the registered previous sample with the current sample.
- The previous sample SHALL be initialised at arming, so an edge coinciding with the accept cycle SHALL NOT count.
- X/Z values SHALL never count as an edge.
REQ-020 SHALL assert o_wait_done in the cycle after the clk edge that samples the qualifying transition (latency 1).
REQ-021 SHALL treat an edge and timeout expiry in the same cycle as an event: no timeout message.
REQ-022 SHALL produce o_wait_done as a registered output, high for exactly one cycle per accepted command.

Reset
REQ-023 SHALL, while rst_n=0, hold state IDLE, o_wait_done=0, timeout counter=0 and previous sample=0.
REQ-024 SHALL, on reset asserted mid-wait, abort the wait immediately with no o_wait_done pulse.
- After release, the block SHALL accept a new command on the first valid cycle.

Configuration
REQ-025 SHALL support macro WAIT_EVENT_TIMEOUT_EN.
- When defined: the timeout counter is active, and on expiry the block SHALL $display "WAIT TIMEOUT <alias>" and pulse o_wait_done.
- When undefined: no counter is compiled, i_args[2..3] SHALL be ignored, and ARMED waits indefinitely for the edge.

Structure
REQ-026 SHALL place the following in package wait_event_pkg:
- state enum (IDLE, ARMED, DONE);
- command constants "WTR" and "WTF";
- unit-to-ps conversion function.
REQ-027 SHALL place the timeout counter in sub-module wait_event_timer, with ports load, value, expired.
- It SHALL be instantiated only under WAIT_EVENT_TIMEOUT_EN.

Verification
Common setup: CLK_PERIOD=20000 ps.
REQ-028 SHALL verify: "WTR O1 100 us" with O1 rising 10 cycles later -> o_wait_done pulses 1 cycle, 11 cycles after accept.
REQ-029 SHALL verify: "WTF RST_N 1 ms" with RST_N held at 1 (macro defined) -> timeout message; o_wait_done pulses 50000 cycles after accept.
REQ-030 SHALL verify: "WTR BAD 10 ns" -> alias error message; o_wait_done pulses the next cycle.
REQ-031 SHALL verify: a second "WTR O2 ..." issued while ARMED on O1 -> ignored; only the O1 edge produces the single o_wait_done.
REQ-032 SHALL verify: rst_n pulsed low for 2 cycles while ARMED -> no o_wait_done; a following "WTR O3 1 us" completes normally.
REQ-033 SHALL verify: "WTR O4 40 ns" with O4 rising exactly at cycle 2 -> single event pulse, no timeout message.
